// File: rtl/activation_array.sv
// Array of NUM_CH integrate-and-fire neurons with windowed spike counting.
// Optional leak: define ACT_LEAK_EN to subtract acc >>> LEAK_SHIFT before each integration.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; accumulators and counts are zero
// RUN   | accepting input current vectors until num_steps are taken
// DONE  | counts presented on accumulated_spikes until out_ready
module activation_array #(
    parameter int NUM_CH      = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMER_WIDTH = 5,
    parameter int LEAK_SHIFT  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [TIMER_WIDTH-1:0]          num_steps,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    threshold,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    membrane_potential,
    output logic [NUM_CH-1:0]               spike,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_CH*TIMER_WIDTH-1:0]   accumulated_spikes,
    output logic                            busy
);

    localparam int ACC_W = DATA_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        state, state_nxt;
    logic [TIMER_WIDTH-1:0]        step_cnt;
    logic [TIMER_WIDTH-1:0]        num_steps_q;
    logic signed [DATA_WIDTH-1:0]  thr_q   [NUM_CH];
    logic signed [ACC_W-1:0]       acc     [NUM_CH];
    logic signed [ACC_W-1:0]       acc_nxt [NUM_CH];
    logic [TIMER_WIDTH-1:0]        cnt     [NUM_CH];
    logic [NUM_CH-1:0]             fire;
    logic                          accept;
    logic                          last_step;

    if (LEAK_SHIFT < 0 || LEAK_SHIFT >= ACC_W) begin : g_bad_leak
        $error("activation_array: LEAK_SHIFT out of range");
    end

    assign in_ready  = (state == RUN);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_step = (TIMER_WIDTH'(step_cnt + 1'b1) == num_steps_q);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] din;
        logic signed [ACC_W-1:0]      acc_base;
        logic signed [ACC_W:0]        sum;
        logic signed [ACC_W-1:0]      acc_sat;
        logic signed [ACC_W-1:0]      thr_ext;
        logic                         thr_pos;

        assign din = membrane_potential[g*DATA_WIDTH +: DATA_WIDTH];
`ifdef ACT_LEAK_EN
        assign acc_base = acc[g] - (acc[g] >>> LEAK_SHIFT);
`else
        assign acc_base = acc[g];
`endif
        assign sum = {acc_base[ACC_W-1], acc_base}
                   + {{(ACC_W + 1 - DATA_WIDTH){din[DATA_WIDTH-1]}}, din};

        // Top two sum bits disagree only on overflow; clamp instead of wrapping.
        always_comb begin
            acc_sat = sum[ACC_W-1:0];
            if (sum[ACC_W] != sum[ACC_W-1])
                acc_sat = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end

        assign thr_ext    = {{(ACC_W - DATA_WIDTH){thr_q[g][DATA_WIDTH-1]}}, thr_q[g]};
        assign thr_pos    = !thr_q[g][DATA_WIDTH-1] && (thr_q[g] != '0);
        assign fire[g]    = thr_pos && (acc_sat >= thr_ext);
        assign acc_nxt[g] = fire[g] ? (acc_sat - thr_ext) : acc_sat;

        assign accumulated_spikes[g*TIMER_WIDTH +: TIMER_WIDTH] = cnt[g];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (num_steps == '0) ? DONE : RUN;
            RUN:  if (accept && last_step) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            step_cnt    <= '0;
            num_steps_q <= '0;
            spike       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                thr_q[i] <= '0;
                acc[i]   <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            spike <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_steps_q <= num_steps;
                        step_cnt    <= '0;
                        for (int i = 0; i < NUM_CH; i++)
                            thr_q[i] <= threshold[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                RUN: begin
                    if (accept) begin
                        step_cnt <= step_cnt + 1'b1;
                        spike    <= fire;
                        for (int i = 0; i < NUM_CH; i++) begin
                            acc[i] <= acc_nxt[i];
                            if (fire[i]) cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        step_cnt <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            acc[i] <= '0;
                            cnt[i] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_array.sv
// Directed self-checking bench for activation_array (3 channels, 16-bit data, LEAK_SHIFT=1).
module tb_activation_array;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]  num_steps;
    logic [47:0] threshold, membrane_potential;
    logic [2:0]  spike;
    logic [14:0] accumulated_spikes;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    activation_array #(
        .NUM_CH(3), .DATA_WIDTH(16), .TIMER_WIDTH(5), .LEAK_SHIFT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
        .threshold(threshold), .in_valid(in_valid), .in_ready(in_ready),
        .membrane_potential(membrane_potential), .spike(spike),
        .out_valid(out_valid), .out_ready(out_ready),
        .accumulated_spikes(accumulated_spikes), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [4:0] ns, input logic [15:0] t0, t1, t2);
        num_steps = ns;
        threshold = {t2, t1, t0};
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic drive(input logic [15:0] a0, a1, a2);
        membrane_potential = {a2, a1, a0};
    endtask

    task automatic feed(input int n);
        in_valid = 1'b1;
        repeat (n) cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!out_valid && k < 40) begin
            cyc();
            k++;
        end
        chk({tag, "_out_valid"}, out_valid, 1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk({tag, "_hs_busy"}, busy, 0);
        chk({tag, "_hs_out_valid"}, out_valid, 0);
        chk({tag, "_hs_counts"}, accumulated_spikes, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        num_steps = '0; threshold = '0; membrane_potential = '0;
        cyc();
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_spike", spike, 0);
        chk("rst_counts", accumulated_spikes, 0);
        rst = 1'b0;

        // basic window: thresholds 10/20/30, constant input 5
        launch(12, 16'd10, 16'd20, 16'd30);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_busy", busy, 1);
        drive(16'd5, 16'd5, 16'd5);
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk($sformatf("t1_spike_%0d", k), spike, {k % 6 == 5, k % 4 == 3, k % 2 == 1});
            chk($sformatf("t1_out_valid_%0d", k), out_valid, k == 11);
        end
        in_valid = 1'b0;
        chk("t1_counts", accumulated_spikes, {5'd2, 5'd3, 5'd6});
        handshake("t1");

        // in_valid toggling every cycle
        launch(12, 16'd10, 16'd20, 16'd30);
        for (int k = 0; k < 23; k++) begin
            in_valid = (k % 2 == 0);
            chk($sformatf("t2_in_ready_%0d", k), in_ready, 1);
            cyc();
            chk($sformatf("t2_out_valid_%0d", k), out_valid, k == 22);
        end
        in_valid = 1'b0;
        chk("t2_counts", accumulated_spikes, {5'd2, 5'd3, 5'd6});

        // back-pressure in DONE with start pulses that must be ignored
        for (int k = 0; k < 5; k++) begin
            start     = (k % 2 == 0);
            num_steps = 5'd0;
            cyc();
            chk($sformatf("t3_out_valid_%0d", k), out_valid, 1);
            chk($sformatf("t3_counts_%0d", k), accumulated_spikes, {5'd2, 5'd3, 5'd6});
            chk($sformatf("t3_in_ready_%0d", k), in_ready, 0);
        end
        start = 1'b0;
        handshake("t3");
        cyc();
        chk("t3_idle_busy", busy, 0);

        // zero-length window
        launch(0, 16'd10, 16'd20, 16'd30);
        chk("t4_out_valid", out_valid, 1);
        chk("t4_counts", accumulated_spikes, 0);
        handshake("t4");

        // zero and negative thresholds disable a channel
        launch(4, 16'd100, 16'd0, 16'hFFFB);
        drive(16'd100, 16'd100, 16'd100);
        feed(4);
        wait_done("t5");
        chk("t5_counts", accumulated_spikes, {5'd0, 5'd0, 5'd4});
        handshake("t5");

        // negative saturation then recovery: acc pinned at -2^17, first spike at step 15
        launch(16, 16'd10, 16'd0, 16'd0);
        drive(16'h8000, 16'd0, 16'd0);
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 10) drive(16'h7FFF, 16'd0, 16'd0);
            cyc();
            chk($sformatf("t6_spike_%0d", k), spike, {2'b00, k >= 14});
        end
        in_valid = 1'b0;
        chk("t6_out_valid", out_valid, 1);
        chk("t6_counts", accumulated_spikes, {5'd0, 5'd0, 5'd2});
        handshake("t6");

        // reset in the middle of a window, then a fresh window
        launch(12, 16'd10, 16'd20, 16'd30);
        drive(16'd5, 16'd5, 16'd5);
        feed(6);
        chk("t7_spike_step6", spike, 3'b101);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t7_busy", busy, 0);
        chk("t7_spike", spike, 0);
        chk("t7_in_ready", in_ready, 0);
        chk("t7_out_valid", out_valid, 0);
        chk("t7_counts", accumulated_spikes, 0);
        launch(12, 16'd10, 16'd20, 16'd30);
        feed(12);
        wait_done("t7b");
        chk("t7b_counts", accumulated_spikes, {5'd2, 5'd3, 5'd6});
        handshake("t7b");

        // leak: with shift 1 acc runs 8,12,14,15,16(fire->0),8,12,14
        launch(8, 16'd16, 16'd0, 16'd0);
        drive(16'd8, 16'd0, 16'd0);
        feed(8);
        wait_done("t8");
`ifdef ACT_LEAK_EN
        chk("t8_counts", accumulated_spikes, {5'd0, 5'd0, 5'd1});
`else
        chk("t8_counts", accumulated_spikes, {5'd0, 5'd0, 5'd4});
`endif
        handshake("t8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
